// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request/response bundle plus the single RAM port.
// slave is the arbiter's view; master is the environment (caches and RAM).
interface mem_arbiter_if #(
  parameter int unsigned CPUS = 2
);
  localparam int unsigned WORD_W = 32;

  // per-CPU instruction cache port
  logic [CPUS-1:0]             iREN;
  logic [CPUS-1:0][WORD_W-1:0] iaddr;
  logic [CPUS-1:0]             iwait;
  logic [CPUS-1:0][WORD_W-1:0] iload;

  // per-CPU data cache port
  logic [CPUS-1:0]             dREN;
  logic [CPUS-1:0]             dWEN;
  logic [CPUS-1:0][WORD_W-1:0] daddr;
  logic [CPUS-1:0][WORD_W-1:0] dstore;
  logic [CPUS-1:0]             dwait;
  logic [CPUS-1:0][WORD_W-1:0] dload;

  // RAM port
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the single RAM port to one icache/dcache port at a time.
// Data beats instruction, round-robin per class, and a data grant is held for
// the two-word block. Optional MEM_ARBITER_STARVE_GUARD_EN forces an
// instruction grant after STARVE_LIMIT data grants made while iREN waits.
module mem_arbiter #(
  parameter int unsigned CPUS         = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  localparam int unsigned CW       = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic {IDLE, SERVE} state_t;
  typedef enum logic {GNT_I, GNT_D} gtype_t;
  typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

  // The starve counter is 4 bits wide, so the limit has to fit in it.
  if (STARVE_LIMIT >= (1 << STARVE_W)) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT does not fit the 4-bit starve counter");
  end

  state_t          state_q, state_nx;
  gtype_t          gtype_q, gtype_nx;
  logic [CW-1:0]   gcpu_q, gcpu_nx;
  logic            beat_q, beat_nx;
  logic [CW-1:0]   rr_d_q, rr_d_nx;
  logic [CW-1:0]   rr_i_q, rr_i_nx;

  logic [CPUS-1:0] d_req;
  logic            d_hit, i_hit;
  logic [CW-1:0]   d_pick, i_pick;
  logic            g_active;
  logic [CW-1:0]   gcpu_inc;
  logic            force_i;
  ramstate_t       ram_st;

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  logic [STARVE_W-1:0] starve_q, starve_nx;
`endif

  // First requester at or after ptr, wrapping modulo CPUS; MSB flags a hit.
  function automatic logic [CW:0] rr_pick(input logic [CPUS-1:0] req,
                                          input logic [CW-1:0]   ptr);
    logic          hit;
    logic [CW-1:0] sel;
    logic [CW-1:0] cand;
    int unsigned   idx;
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < CPUS; k++) begin
      idx  = (32'(ptr) + 32'(k)) % CPUS;
      cand = CW'(idx);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
    return {hit, sel};
  endfunction

  // Request decode and candidate selection for the next IDLE decision.
  assign d_req             = bus.dREN | bus.dWEN;
  assign {d_hit, d_pick}   = rr_pick(d_req, rr_d_q);
  assign {i_hit, i_pick}   = rr_pick(bus.iREN, rr_i_q);
  assign g_active          = (gtype_q == GNT_D) ? d_req[gcpu_q] : bus.iREN[gcpu_q];
  assign gcpu_inc          = (gcpu_q == CW'(CPUS - 1)) ? '0 : gcpu_q + CW'(1);
  assign ram_st            = ramstate_t'(bus.ramstate);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
  assign force_i = (starve_q == STARVE_W'(STARVE_LIMIT)) && i_hit;
`else
  assign force_i = 1'b0;
`endif

  // ramload is broadcast; only the port seeing wait=0 consumes it.
  assign bus.iload = {CPUS{bus.ramload}};
  assign bus.dload = {CPUS{bus.ramload}};

  // State register; async reset abandons any in-flight word.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      gtype_q  <= GNT_I;
      gcpu_q   <= '0;
      beat_q   <= 1'b0;
      rr_d_q   <= '0;
      rr_i_q   <= '0;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_nx;
      gtype_q  <= gtype_nx;
      gcpu_q   <= gcpu_nx;
      beat_q   <= beat_nx;
      rr_d_q   <= rr_d_nx;
      rr_i_q   <= rr_i_nx;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
      starve_q <= starve_nx;
`endif
    end
  end

  // Next-state arbitration and RAM/wait drive.
  always_comb begin
    state_nx     = state_q;
    gtype_nx     = gtype_q;
    gcpu_nx      = gcpu_q;
    beat_nx      = beat_q;
    rr_d_nx      = rr_d_q;
    rr_i_nx      = rr_i_q;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    starve_nx    = (|bus.iREN) ? starve_q : '0;
`endif
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    unique case (state_q)
      IDLE: begin
        if (force_i || (!d_hit && i_hit)) begin
          state_nx  = SERVE;
          gtype_nx  = GNT_I;
          gcpu_nx   = i_pick;
          beat_nx   = 1'b0;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
          starve_nx = '0;
`endif
        end else if (d_hit) begin
          state_nx  = SERVE;
          gtype_nx  = GNT_D;
          gcpu_nx   = d_pick;
          beat_nx   = 1'b0;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
          if (|bus.iREN) starve_nx = starve_q + STARVE_W'(1);
`endif
        end
      end

      SERVE: begin
        if (gtype_q == GNT_D) begin
          bus.ramaddr  = bus.daddr[gcpu_q];
          bus.ramstore = bus.dstore[gcpu_q];
          bus.ramWEN   = bus.dWEN[gcpu_q];
          bus.ramREN   = bus.dREN[gcpu_q] & ~bus.dWEN[gcpu_q];
        end else begin
          bus.ramaddr  = bus.iaddr[gcpu_q];
          bus.ramREN   = bus.iREN[gcpu_q];
        end

        // Dropped request aborts without moving the pointer; ERROR/BUSY/FREE hold.
        if (!g_active) begin
          state_nx = IDLE;
          beat_nx  = 1'b0;
        end else if (ram_st == RAM_ACCESS) begin
          if (gtype_q == GNT_I) begin
            bus.iwait[gcpu_q] = 1'b0;
            state_nx          = IDLE;
            rr_i_nx           = gcpu_inc;
          end else begin
            bus.dwait[gcpu_q] = 1'b0;
            if (!beat_q) begin
              beat_nx  = 1'b1;
            end else begin
              state_nx = IDLE;
              beat_nx  = 1'b0;
              rr_d_nx  = gcpu_inc;
            end
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected completed
// words, popped by an independent monitor whenever a wait goes low.
module tb_mem_arbiter;
  localparam int unsigned CPUS = 2;

  logic CLK;
  logic nRST;

  mem_arbiter_if #(.CPUS(CPUS)) bus ();

  mem_arbiter #(.CPUS(CPUS), .STARVE_LIMIT(8)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    bit          is_d;
    int          cpu;
    logic [31:0] addr;
    logic [31:0] data;
    bit          wen;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          lat    = 2;
  int          err_left = 0;
  logic [31:0] mem [logic [31:0]];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void push(input bit d, input int c, input logic [31:0] a,
                               input logic [31:0] v, input bit w, input int cy);
    exp_t e;
    e.is_d = d; e.cpu = c; e.addr = a; e.data = v; e.wen = w; e.cyc = cy;
    sb.push_back(e);
  endfunction

  // RAM model: BUSY for lat cycles, optional ERROR cycles, then ACCESS for one.
  initial begin
    bit          acc;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          cnt;
    mem[32'h40]  = 32'hDEADBEEF;
    mem[32'h80]  = 32'hCAFE0080;
    mem[32'h200] = 32'hB0B00200;
    mem[32'h204] = 32'hB0B00204;
    bus.ramstate = 2'd0;
    bus.ramload  = '0;
    cnt = 0;
    forever begin
      @(negedge CLK);
      acc = nRST && (bus.ramstate == 2'd2) && (bus.ramREN || bus.ramWEN);
      wr  = bus.ramWEN;
      a   = bus.ramaddr;
      d   = bus.ramstore;
      @(posedge CLK);
      #2;
      if (acc && wr) mem[a] = d;
      if (!nRST || !(bus.ramREN || bus.ramWEN)) begin
        cnt = 0;
        bus.ramstate = 2'd0;
        bus.ramload  = '0;
      end else begin
        if (acc) cnt = 0;
        cnt++;
        if (cnt <= lat) begin
          bus.ramstate = 2'd1;
          bus.ramload  = '0;
        end else if (err_left > 0) begin
          err_left--;
          bus.ramstate = 2'd3;
        end else begin
          bus.ramstate = 2'd2;
          bus.ramload  = bus.ramWEN ? 32'h0 :
                         (mem.exists(bus.ramaddr) ? mem[bus.ramaddr] : 32'h0);
        end
      end
    end
  end

  // Monitor: every wait-low cycle is a completed word; compare with scoreboard.
  initial begin
    int          lows;
    bit          m_d;
    int          m_c;
    exp_t        e;
    logic [31:0] ld;
    m_d = 1'b0;
    m_c = 0;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        lows = 0;
        for (int k = 0; k < CPUS; k++) begin
          if (!bus.iwait[k]) begin lows++; m_d = 1'b0; m_c = k; end
          if (!bus.dwait[k]) begin lows++; m_d = 1'b1; m_c = k; end
        end
        if (bus.ramstate == 2'd3) begin
          chk("err_hold_dwait", 32'(bus.dwait), 32'h3);
          chk("err_hold_iwait", 32'(bus.iwait), 32'h3);
        end
        if (lows > 1) begin
          chk("single_wait_low", 32'(lows), 32'd1);
        end else if (lows == 1) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got d=%0d cpu=%0d addr=%h expected none",
                     m_d, m_c, bus.ramaddr);
          end else begin
            e  = sb.pop_front();
            ld = m_d ? bus.dload[m_c] : bus.iload[m_c];
            chk("word_class", 32'(m_d), 32'(e.is_d));
            chk("word_cpu", 32'(m_c), 32'(e.cpu));
            chk("word_ramaddr", bus.ramaddr, e.addr);
            if (e.wen) begin
              chk("word_ramWEN", 32'(bus.ramWEN), 32'd1);
              chk("word_ramstore", bus.ramstore, e.data);
            end else begin
              chk("word_ramREN", 32'(bus.ramREN), 32'd1);
              chk("word_load", ld, e.data);
            end
            if (e.cyc >= 0) chk("word_cycle", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  task automatic wait_low(input bit is_d, input int c, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge CLK);
      if (is_d ? !bus.dwait[c] : !bus.iwait[c]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got no wait-low expected one (d=%0d cpu=%0d)", is_d, c);
    end
  endtask

  // Data cache driver: nblk two-word blocks, request held between blocks.
  task automatic d_block(input int c, input bit wen, input logic [31:0] a0,
                         input logic [31:0] s0, input logic [31:0] a1,
                         input logic [31:0] s1, input int nblk);
    bit ok;
    for (int b = 0; b < nblk; b++) begin
      bus.dREN[c]   = !wen;
      bus.dWEN[c]   = wen;
      bus.daddr[c]  = a0;
      bus.dstore[c] = s0;
      wait_low(1'b1, c, 200, ok);
      if (!ok) break;
      @(posedge CLK); #1;
      bus.daddr[c]  = a1;
      bus.dstore[c] = s1;
      @(negedge CLK);
      chk("beat1_strobe", 32'(bus.ramREN | bus.ramWEN), 32'd1);
      chk("beat1_addr", bus.ramaddr, a1);
      wait_low(1'b1, c, 200, ok);
      if (!ok) break;
      @(posedge CLK); #1;
    end
    bus.dREN[c] = 1'b0;
    bus.dWEN[c] = 1'b0;
  endtask

  task automatic i_word(input int c, input logic [31:0] a);
    bit ok;
    bus.iREN[c]  = 1'b1;
    bus.iaddr[c] = a;
    wait_low(1'b0, c, 300, ok);
    @(posedge CLK); #1;
    bus.iREN[c] = 1'b0;
  endtask

  task automatic push_block(input int c, input logic [31:0] a0, input logic [31:0] v0,
                            input logic [31:0] a1, input logic [31:0] v1, input bit w);
    push(1'b1, c, a0, v0, w, -1);
    push(1'b1, c, a1, v1, w, -1);
  endtask

  initial begin
    bit ok;
    int t0;
    nRST       = 1'b0;
    bus.iREN   = '0;
    bus.iaddr  = '0;
    bus.dREN   = '0;
    bus.dWEN   = '0;
    bus.daddr  = '0;
    bus.dstore = '0;
    #2;
    chk("rst_iwait", 32'(bus.iwait), 32'h3);
    chk("rst_dwait", 32'(bus.dwait), 32'h3);
    chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Single instruction fetch, RAM latency 2: wait low in cycle 3.
    lat = 2;
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h40;
    t0 = cyc;
    push(1'b0, 0, 32'h40, 32'hDEADBEEF, 1'b0, t0 + 3);
    @(negedge CLK);
    chk("t1_c0_ramREN", 32'(bus.ramREN), 32'd0);
    @(negedge CLK);
    chk("t1_c1_ramREN", 32'(bus.ramREN), 32'd1);
    chk("t1_c1_ramaddr", bus.ramaddr, 32'h40);
    wait_low(1'b0, 0, 20, ok);
    @(posedge CLK); #1;
    bus.iREN[0] = 1'b0;
    @(negedge CLK);
    chk("t1_back_idle", 32'(bus.ramREN), 32'd0);

    // Write block on CPU1 with a concurrent fetch on CPU0: data first.
    lat = 1;
    @(posedge CLK); #1;
    push_block(1, 32'h100, 32'h11, 32'h104, 32'h22, 1'b1);
    push(1'b0, 0, 32'h80, 32'hCAFE0080, 1'b0, -1);
    fork
      d_block(1, 1'b1, 32'h100, 32'h11, 32'h104, 32'h22, 1);
      i_word(0, 32'h80);
    join

    // Both CPUs reading continuously: CPU0, CPU1, CPU0 blocks.
    @(posedge CLK); #1;
    push_block(0, 32'h100, 32'h11, 32'h104, 32'h22, 1'b0);
    push_block(1, 32'h200, 32'hB0B00200, 32'h204, 32'hB0B00204, 1'b0);
    push_block(0, 32'h100, 32'h11, 32'h104, 32'h22, 1'b0);
    fork
      d_block(0, 1'b0, 32'h100, 32'h0, 32'h104, 32'h0, 2);
      d_block(1, 1'b0, 32'h200, 32'h0, 32'h204, 32'h0, 1);
    join

    // Three ERROR cycles on the first word, then normal completion.
    @(posedge CLK); #1;
    err_left = 3;
    push_block(0, 32'h200, 32'hB0B00200, 32'h204, 32'hB0B00204, 1'b0);
    d_block(0, 1'b0, 32'h200, 32'h0, 32'h204, 32'h0, 1);
    chk("t4_err_consumed", 32'(err_left), 32'd0);

    // Pointer now at CPU1: simultaneous requests serve CPU1 first.
    @(posedge CLK); #1;
    push_block(1, 32'h200, 32'hB0B00200, 32'h204, 32'hB0B00204, 1'b0);
    push_block(0, 32'h100, 32'h11, 32'h104, 32'h22, 1'b0);
    fork
      d_block(0, 1'b0, 32'h100, 32'h0, 32'h104, 32'h0, 1);
      d_block(1, 1'b0, 32'h200, 32'h0, 32'h204, 32'h0, 1);
    join

    // Reset between word 0 and word 1 of a block.
    @(posedge CLK); #1;
    push(1'b1, 0, 32'h100, 32'h11, 1'b0, -1);
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h100;
    wait_low(1'b1, 0, 20, ok);
    @(posedge CLK); #1;
    bus.daddr[0] = 32'h104;
    @(negedge CLK);
    chk("t5_mid_block_ren", 32'(bus.ramREN), 32'd1);
    @(posedge CLK); #3;
    nRST = 1'b0;
    #1;
    chk("t5_rst_iwait", 32'(bus.iwait), 32'h3);
    chk("t5_rst_dwait", 32'(bus.dwait), 32'h3);
    chk("t5_rst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("t5_rst_ramWEN", 32'(bus.ramWEN), 32'd0);
    chk("t5_rst_ramaddr", bus.ramaddr, 32'h0);
    bus.dREN[0]  = 1'b0;
    bus.daddr[0] = '0;
    @(posedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    push_block(0, 32'h100, 32'h11, 32'h104, 32'h22, 1'b0);
    d_block(0, 1'b0, 32'h100, 32'h0, 32'h104, 32'h0, 1);

    // Continuous data on CPU0 against a held fetch on CPU1.
    @(posedge CLK); #1;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
    for (int b = 0; b < 8; b++) push_block(0, 32'h100, 32'h11, 32'h104, 32'h22, 1'b0);
    push(1'b0, 1, 32'h40, 32'hDEADBEEF, 1'b0, -1);
    push_block(0, 32'h100, 32'h11, 32'h104, 32'h22, 1'b0);
`else
    for (int b = 0; b < 9; b++) push_block(0, 32'h100, 32'h11, 32'h104, 32'h22, 1'b0);
    push(1'b0, 1, 32'h40, 32'hDEADBEEF, 1'b0, -1);
`endif
    fork
      d_block(0, 1'b0, 32'h100, 32'h0, 32'h104, 32'h0, 9);
      i_word(1, 32'h40);
    join

    repeat (3) @(posedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
